axi_lite_reg_slave: RTL and testbench

AXI4-Lite slave register file that terminates the master-side control traffic driven by the test bench's master agent onto the DRAM test block's S00_AXI port. It holds NUM_REGS 32-bit control registers, accepts single-beat writes with byte strobes, returns single-beat reads, and exposes all register contents to downstream logic as a flat bus. The write and read channels are independent; each direction allows at most one transaction in flight.

---
 rtl/axi_lite_reg_slave_if.sv | 51 +++++
 rtl/axi_lite_reg_slave.sv | 155 +++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_slave_if.sv
// rtl/axi_lite_reg_slave_if.sv - AXI4-Lite bus bundle between a master agent and the register slave
interface axi_lite_reg_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// rtl/axi_lite_reg_slave.sv - AXI4-Lite register file with byte strobes and flat register output
module axi_lite_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axi_lite_reg_slave_if.slave            s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;

  logic                           aw_full_q, w_full_q;
  logic [IDX_W-1:0]               aw_idx_q;
  logic [DATA_WIDTH-1:0]          wdata_q;
  logic [STRB_W-1:0]              wstrb_q;
  logic [1:0]                     bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]          rdata_q;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q;

  logic awready, wready, arready, bvalid, rvalid;
  logic aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]      c_idx, ar_idx;
  logic [DATA_WIDTH-1:0] c_data, rd_word;
  logic [STRB_W-1:0]     c_strb;
  logic                  wr_hit, rd_hit;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  // Readies are held low while ARESET is high so the bus sees a quiet slave during reset.
  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    awready   = 1'b0;
    wready    = 1'b0;
    arready   = 1'b0;
    bvalid    = 1'b0;
    rvalid    = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    ar_hs     = 1'b0;
    commit    = 1'b0;
    if (!ARESET) begin
      if (w_state_q == W_IDLE) begin
        awready = !aw_full_q;
        wready  = !w_full_q;
        aw_hs   = awready && s_axi.S_AXI_AWVALID;
        w_hs    = wready && s_axi.S_AXI_WVALID;
        commit  = (aw_full_q || aw_hs) && (w_full_q || w_hs);
        if (commit) w_state_d = W_RESP;
      end else begin
        bvalid = 1'b1;
        if (s_axi.S_AXI_BREADY) w_state_d = W_IDLE;
      end
      if (r_state_q == R_IDLE) begin
        arready = 1'b1;
        ar_hs   = s_axi.S_AXI_ARVALID;
        if (ar_hs) r_state_d = R_DATA;
      end else begin
        rvalid = 1'b1;
        if (s_axi.S_AXI_RREADY) r_state_d = R_IDLE;
      end
    end
  end

  // The commit uses live bus values for whichever half arrives on the committing edge.
  assign c_idx  = aw_full_q ? aw_idx_q : s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign c_data = w_full_q ? wdata_q : s_axi.S_AXI_WDATA;
  assign c_strb = w_full_q ? wstrb_q : s_axi.S_AXI_WSTRB;
  assign ar_idx = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2];

  always_comb begin
    wr_hit  = 1'b0;
    rd_hit  = 1'b0;
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (c_idx == IDX_W'(k)) wr_hit = 1'b1;
      if (ar_idx == IDX_W'(k)) begin
        rd_hit  = 1'b1;
        rd_word = regs_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      regs_q    <= '0;
    end else begin
      if (aw_hs && !commit) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_hs && !commit) begin
        w_full_q <= 1'b1;
        wdata_q  <= s_axi.S_AXI_WDATA;
        wstrb_q  <= s_axi.S_AXI_WSTRB;
      end
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bresp_q   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
        for (int k = 0; k < NUM_REGS; k++) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (c_idx == IDX_W'(k) && c_strb[b])
              regs_q[k*DATA_WIDTH + b*8 +: 8] <= c_data[b*8 +: 8];
          end
        end
      end
      if (ar_hs) begin
        rdata_q <= rd_word;
        rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign reg_out             = regs_q;

  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb/tb_axi_lite_reg_slave.sv - randomized self-checking bench for axi_lite_reg_slave
module tb_axi_lite_reg_slave;
  localparam int AW = 5;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_reg_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) bus ();
  logic [NR*32-1:0] reg_out;

  axi_lite_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .s_axi  (bus),
    .reg_out(reg_out)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [NR];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f;
    for (int k = 0; k < NR; k++) f[k*32 +: 32] = model[k];
    return f;
  endfunction

  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_start, input int w_start,
                          input int hold);
    logic aw_done = 1'b0;
    logic w_done  = 1'b0;
    logic aw_fire, w_fire;
    logic [1:0] exp_resp;
    int idx;
    idx = int'(addr[AW-1:2]);
    exp_resp = (idx < NR) ? 2'b00 : 2'b10;
    for (int cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
      @(negedge clk);
      check("wr_early_bvalid", bus.S_AXI_BVALID, 1'b0);
      if (w_done && !aw_done) check("wr_wready_held", bus.S_AXI_WREADY, 1'b0);
      if (aw_done && !w_done) check("wr_awready_held", bus.S_AXI_AWREADY, 1'b0);
      if (!aw_done && cyc >= aw_start) begin
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_AWADDR  = addr;
      end
      if (!w_done && cyc >= w_start) begin
        bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_WDATA  = data;
        bus.S_AXI_WSTRB  = strb;
      end
      aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_fire  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(posedge clk);
      #1;
      if (aw_fire) begin aw_done = 1'b1; bus.S_AXI_AWVALID = 1'b0; end
      if (w_fire)  begin w_done = 1'b1;  bus.S_AXI_WVALID = 1'b0; end
    end
    if (!(aw_done && w_done)) begin
      check("wr_handshake_timeout", 1'b0, 1'b1);
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      return;
    end
    if (idx < NR)
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    @(negedge clk);
    check("wr_bvalid", bus.S_AXI_BVALID, 1'b1);
    check("wr_bresp", bus.S_AXI_BRESP, exp_resp);
    check("wr_reg_out", reg_out, model_flat());
    check("wr_awready_busy", bus.S_AXI_AWREADY, 1'b0);
    check("wr_wready_busy", bus.S_AXI_WREADY, 1'b0);
    for (int h = 0; h < hold; h++) begin
      bus.S_AXI_BREADY = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("wr_hold_bvalid", bus.S_AXI_BVALID, 1'b1);
      check("wr_hold_bresp", bus.S_AXI_BRESP, exp_resp);
      check("wr_hold_awready", bus.S_AXI_AWREADY, 1'b0);
      check("wr_hold_wready", bus.S_AXI_WREADY, 1'b0);
    end
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk);
    #1 bus.S_AXI_BREADY = 1'b0;
    @(negedge clk);
    check("wr_bvalid_drop", bus.S_AXI_BVALID, 1'b0);
    check("wr_awready_back", bus.S_AXI_AWREADY, 1'b1);
    check("wr_wready_back", bus.S_AXI_WREADY, 1'b1);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int hold);
    logic fired = 1'b0;
    logic [31:0] exp_data;
    logic [1:0] exp_resp;
    int idx;
    idx = int'(addr[AW-1:2]);
    exp_data = '0;
    exp_resp = 2'b10;
    for (int cyc = 0; cyc < 40 && !fired; cyc++) begin
      @(negedge clk);
      bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_ARADDR  = addr;
      if (bus.S_AXI_ARREADY) begin
        fired = 1'b1;
        if (idx < NR) begin
          exp_data = model[idx];
          exp_resp = 2'b00;
        end
      end
      @(posedge clk);
      #1;
      if (fired) bus.S_AXI_ARVALID = 1'b0;
    end
    if (!fired) begin
      check("rd_handshake_timeout", 1'b0, 1'b1);
      bus.S_AXI_ARVALID = 1'b0;
      return;
    end
    @(negedge clk);
    check("rd_rvalid", bus.S_AXI_RVALID, 1'b1);
    check("rd_rdata", bus.S_AXI_RDATA, exp_data);
    check("rd_rresp", bus.S_AXI_RRESP, exp_resp);
    check("rd_arready_busy", bus.S_AXI_ARREADY, 1'b0);
    for (int h = 0; h < hold; h++) begin
      bus.S_AXI_RREADY = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rd_hold_rvalid", bus.S_AXI_RVALID, 1'b1);
      check("rd_hold_rdata", bus.S_AXI_RDATA, exp_data);
      check("rd_hold_rresp", bus.S_AXI_RRESP, exp_resp);
      check("rd_hold_arready", bus.S_AXI_ARREADY, 1'b0);
    end
    bus.S_AXI_RREADY = 1'b1;
    @(posedge clk);
    #1 bus.S_AXI_RREADY = 1'b0;
    @(negedge clk);
    check("rd_rvalid_drop", bus.S_AXI_RVALID, 1'b0);
    check("rd_arready_back", bus.S_AXI_ARREADY, 1'b1);
  endtask

  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    for (int k = 0; k < NR; k++) model[k] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", bus.S_AXI_AWREADY, 1'b0);
    check("rst_wready", bus.S_AXI_WREADY, 1'b0);
    check("rst_arready", bus.S_AXI_ARREADY, 1'b0);
    check("rst_bvalid", bus.S_AXI_BVALID, 1'b0);
    check("rst_rvalid", bus.S_AXI_RVALID, 1'b0);
    check("rst_bresp", bus.S_AXI_BRESP, 2'b00);
    check("rst_rresp", bus.S_AXI_RRESP, 2'b00);
    check("rst_rdata", bus.S_AXI_RDATA, 32'h0);
    check("rst_reg_out", reg_out, '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", bus.S_AXI_AWREADY, 1'b1);
    check("post_rst_wready", bus.S_AXI_WREADY, 1'b1);
    check("post_rst_arready", bus.S_AXI_ARREADY, 1'b1);

    for (int i = 0; i < NR; i++) do_write(AW'(i*4), 32'(i+1), 4'hF, 0, 0, 0);
    check("seq_reg_out", reg_out, {32'h4, 32'h3, 32'h2, 32'h1});
    for (int i = 0; i < NR; i++) do_read(AW'(i*4), 0);

    do_write(5'h00, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(5'h00, 32'h11223344, 4'b0101, 0, 0, 0);
    do_read(5'h00, 0);
    check("strb_model", model[0], 32'hAA22CC44);

    do_write(5'h04, $urandom, 4'hF, 3, 0, 0);
    do_write(5'h08, $urandom, 4'hF, 0, 2, 0);
    do_write(5'h0C, $urandom, 4'hF, 0, 0, 0);

    do_write(5'h0C, $urandom, 4'hF, 0, 0, 5);
    do_read(5'h0C, 5);

    do_write(5'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(5'h14, 0);
    do_write(5'h05, $urandom, 4'h0, 0, 0, 0);

    fork
      do_write(5'h04, 32'h5A5A0000, 4'hF, 0, 0, 0);
      do_read(5'h04, 0);
    join

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(1, 0) == 0)
        do_write(AW'($urandom_range(31, 0)), $urandom, 4'($urandom_range(15, 0)),
                 $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(2, 0));
      else
        do_read(AW'($urandom_range(31, 0)), $urandom_range(2, 0));
    end

    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_AWADDR  = 5'h04;
    @(posedge clk);
    #1 bus.S_AXI_AWVALID = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_reg_out", reg_out, '0);
    check("midrst_bvalid", bus.S_AXI_BVALID, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < NR; k++) model[k] = '0;
    bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_WDATA  = 32'hCAFEF00D;
    bus.S_AXI_WSTRB  = 4'hF;
    @(posedge clk);
    #1 bus.S_AXI_WVALID = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("midrst_no_bvalid", bus.S_AXI_BVALID, 1'b0);
    end
    for (int i = 0; i < NR; i++) do_read(AW'(i*4), 0);
    check("midrst_final_reg_out", reg_out, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end
endmodule
